// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//
// Control block for a downstream 4-bit counter. It produces a registered,
// single-cycle increment pulse (enable) either continuously through a
// programmable prescaler (RUN), or once on request (STEP). It can optionally
// auto-halt when the downstream counter is about to reach 4'hF, so the counter
// parks at 15 and never wraps.
//
// Ports
//   clock       : single clock, all state updates on the rising edge
//   reset       : synchronous, active-low reset
//   start       : level input, rising edge requests free-run mode
//   stop        : level input, rising edge requests halt
//   step        : level input, rising edge requests one single increment
//   div         : prescale value, pulse period in RUN is div+1 cycles
//   stop_at_tc  : 1 = auto-halt when the projected counter value is 4'hF
//   count_in    : feedback from the downstream 4-bit counter output
//   enable      : registered single-cycle increment pulse to the counter
//   running     : high while the FSM is in RUN
//   done        : registered one-cycle pulse on auto-halt
// -----------------------------------------------------------------------------
module counter_ctrl #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [DIV_W-1:0] div,
    input  logic             stop_at_tc,
    input  logic [3:0]       count_in,
    output logic             enable,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             enable_q, enable_d;
    logic             done_q, done_d;

    // Previous values of the request inputs, used for rising-edge detection.
    logic             start_prev_q, stop_prev_q, step_prev_q;

    logic             start_edge, stop_edge, step_edge;
    logic [3:0]       proj_count;
    logic             tc_hit;
    logic             presc_hit;

    assign start_edge = start & ~start_prev_q;
    assign stop_edge  = stop  & ~stop_prev_q;
    assign step_edge  = step  & ~step_prev_q;

    // Value the downstream counter will hold after this edge: it increments
    // on the enable pulse currently being presented to it.
    assign proj_count = count_in + {3'b000, enable_q};
    assign tc_hit     = stop_at_tc & (proj_count == 4'hF);

    // Greater-or-equal (not equality) so that lowering div below the current
    // prescaler value fires on the next cycle instead of wrapping around.
    assign presc_hit  = (presc_q >= div);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            enable_q     <= 1'b0;
            done_q       <= 1'b0;
            // History resets high: an input held high through reset must
            // fall and rise again before it counts as a request.
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            step_prev_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            enable_q     <= enable_d;
            done_q       <= done_d;
            start_prev_q <= start;
            stop_prev_q  <= stop;
            step_prev_q  <= step;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        enable_d = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (stop_edge) begin
                    // A stop request outranks a simultaneous start or step.
                    state_d = ST_IDLE;
                end else if (start_edge) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end else if (step_edge) begin
                    state_d = ST_STEP;
                end
            end

            ST_STEP: begin
                // One-cycle state; request edges seen here are dropped.
                state_d  = ST_IDLE;
                enable_d = 1'b1;
            end

            ST_RUN: begin
                // Priority: stop, then terminal count, then prescaler. Start
                // and step edges are ignored while running.
                if (stop_edge) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (tc_hit) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    done_d  = 1'b1;
                end else if (presc_hit) begin
                    presc_d  = '0;
                    enable_d = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase
    end

    assign enable  = enable_q;
    assign done    = done_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
//
// Directed testbench for counter_ctrl. A behavioural 4-bit counter closes the
// count_in feedback loop. Inputs are driven and outputs observed on the
// falling clock edge; "Nk" in the comments is the k-th falling edge after the
// falling edge on which the stimulus was applied, i.e. the one following
// rising edge E0+k-1.
// -----------------------------------------------------------------------------
module tb_counter_ctrl;

    localparam int DIV_W = 8;

    logic             clock;
    logic             reset;
    logic             start;
    logic             stop;
    logic             step;
    logic [DIV_W-1:0] div;
    logic             stop_at_tc;
    logic [3:0]       count_in;
    logic             enable;
    logic             running;
    logic             done;

    logic [3:0]       cnt;
    logic             cnt_clr;

    int n_checks;
    int n_fail;

    counter_ctrl #(.DIV_W(DIV_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .div        (div),
        .stop_at_tc (stop_at_tc),
        .count_in   (count_in),
        .enable     (enable),
        .running    (running),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream 4-bit counter model.
    always_ff @(posedge clock) begin
        if (cnt_clr)
            cnt <= 4'h0;
        else if (enable)
            cnt <= cnt + 4'h1;
    end
    assign count_in = cnt;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic clear_counter();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (running !== 1'b0 || enable !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state running=%b enable=%b done=%b expected 0/0/0",
                     running, enable, done);
        end
        reset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (running !== 1'b0 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle running=%b enable=%b expected 0/0", running, enable);
        end
    endtask

    // div=3: running next cycle, pulses at N5, N9, N13, then stop.
    task automatic test_run_div3();
        logic exp_en;
        div   = 8'd3;
        start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp_en = (k >= 5) && ((k - 5) % 4 == 0);
            n_checks++;
            if (enable !== exp_en || running !== 1'b1) begin
                n_fail++;
                $display("FAIL run_div3 k=%0d enable=%b running=%b expected %b/1",
                         k, enable, running, exp_en);
            end
        end
        start = 1'b0;
        stop  = 1'b1;
        tick();
        n_checks++;
        if (running !== 1'b0 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL run_div3_stop running=%b enable=%b expected 0/0", running, enable);
        end
        stop = 1'b0;
        tick();
    endtask

    task automatic test_start_stop_same();
        start = 1'b1;
        stop  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (running !== 1'b0 || enable !== 1'b0) begin
                n_fail++;
                $display("FAIL start_stop_same k=%0d running=%b enable=%b expected 0/0",
                         k, running, enable);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        tick();
    endtask

    // div=3: presc==div at E8; stop rising there must suppress that pulse.
    task automatic test_stop_at_fire();
        div   = 8'd3;
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (enable !== (k == 5)) begin
                n_fail++;
                $display("FAIL stop_at_fire_pre k=%0d enable=%b expected %b", k, enable, (k == 5));
            end
        end
        start = 1'b0;
        stop  = 1'b1;
        for (int k = 9; k <= 12; k++) begin
            tick();
            n_checks++;
            if (running !== 1'b0 || enable !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_at_fire k=%0d running=%b enable=%b expected 0/0",
                         k, running, enable);
            end
        end
        stop = 1'b0;
        tick();
    endtask

    // div=10; after E7 presc=7, div drops to 2 -> pulses at N9, N12, N15.
    task automatic test_div_change();
        logic exp_en;
        div   = 8'd10;
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp_en = (k == 9) || (k == 12) || (k == 15);
            n_checks++;
            if (enable !== exp_en) begin
                n_fail++;
                $display("FAIL div_change k=%0d enable=%b expected %b", k, enable, exp_en);
            end
            if (k == 8) div = 8'd2;
        end
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_step();
        clear_counter();
        stop_at_tc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            n_checks++;
            if (enable !== 1'b0 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL step_enter i=%0d enable=%b running=%b expected 0/0",
                         i, enable, running);
            end
            step = 1'b0;
            tick();
            n_checks++;
            if (enable !== 1'b1) begin
                n_fail++;
                $display("FAIL step_pulse i=%0d enable=%b expected 1", i, enable);
            end
            tick();
            n_checks++;
            if (enable !== 1'b0) begin
                n_fail++;
                $display("FAIL step_single i=%0d enable=%b expected 0", i, enable);
            end
        end
        n_checks++;
        if (cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL step_count count=%0d expected 3", cnt);
        end
    endtask

    // div=0, auto-halt: pulses N2..N16, done at N17 only, counter parks at 15.
    task automatic test_tc_halt();
        logic exp_en, exp_done, exp_run;
        clear_counter();
        div        = 8'd0;
        stop_at_tc = 1'b1;
        start      = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_en   = (k >= 2) && (k <= 16);
            exp_done = (k == 17);
            exp_run  = (k <= 16);
            n_checks++;
            if (enable !== exp_en || done !== exp_done || running !== exp_run) begin
                n_fail++;
                $display("FAIL tc_halt k=%0d enable=%b done=%b running=%b expected %b/%b/%b",
                         k, enable, done, running, exp_en, exp_done, exp_run);
            end
        end
        n_checks++;
        if (cnt !== 4'hF) begin
            n_fail++;
            $display("FAIL tc_hold count=%0d expected 15", cnt);
        end
        start      = 1'b0;
        stop_at_tc = 1'b0;
        tick();
    endtask

    // div=0, no auto-halt: counter wraps; start/step edges in RUN ignored.
    task automatic test_wrap_and_ignore();
        clear_counter();
        div        = 8'd0;
        stop_at_tc = 1'b0;
        start      = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_checks++;
            if (enable !== (k >= 2) || done !== 1'b0 || running !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap k=%0d enable=%b done=%b running=%b expected %b/0/1",
                         k, enable, done, running, (k >= 2));
            end
            if (k == 5)  start = 1'b0;
            if (k == 7)  start = 1'b1;
            if (k == 9)  step  = 1'b1;
            if (k == 11) step  = 1'b0;
        end
        n_checks++;
        if (cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL wrap_count count=%0d expected 2", cnt);
        end
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        div   = 8'd0;
        start = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (enable !== 1'b1 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_pre enable=%b running=%b expected 1/1", enable, running);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (enable !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset enable=%b running=%b expected 0/0", enable, running);
        end
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (enable !== 1'b0 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_run_after k=%0d enable=%b running=%b expected 0/0",
                         k, enable, running);
            end
        end
    endtask

    task automatic test_reset_held_start();
        start = 1'b1;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (running !== 1'b0) begin
                n_fail++;
                $display("FAIL held_start k=%0d running=%b expected 0", k, running);
            end
        end
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL held_start_rearm running=%b expected 1", running);
        end
        start = 1'b0;
        stop  = 1'b1;
        tick();
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL held_start_stop running=%b expected 0", running);
        end
        stop = 1'b0;
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        step       = 1'b0;
        div        = '0;
        stop_at_tc = 1'b0;
        cnt_clr    = 1'b1;
        tick();
        cnt_clr    = 1'b0;

        test_reset();
        test_run_div3();
        test_start_stop_same();
        test_stop_at_fire();
        test_div_change();
        test_step();
        test_tc_halt();
        test_wrap_and_ignore();
        test_reset_mid_run();
        test_reset_held_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter DIV_W, default 8, width of the prescaler divide value.
REQ-002 clock  input  1  Single clock; all state updates on the rising edge.
REQ-003 reset  input  1  Synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 start  input  1  Level input; a rising edge requests free-run mode.
REQ-005 stop  input  1  Level input; a rising edge requests halt.
REQ-006 step  input  1  Level input; a rising edge requests one single increment.
REQ-007 div  input  DIV_W  Prescale value; pulse period in RUN is div+1 cycles.
REQ-008 stop_at_tc  input  1  1 = auto-halt when the downstream 4-bit counter reaches 4'hF.
REQ-009 count_in  input  4  Feedback from the downstream 4-bit counter output.
REQ-010 enable  output  1  Registered single-cycle increment pulse driving the counter enable.
REQ-011 running  output  1  High while the FSM is in RUN.
REQ-012 done  output  1  Registered one-cycle pulse on auto-halt.

Function
REQ-013 start, stop and step SHALL each be edge-detected against a registered previous value; edge = input & ~prev. Inputs are synchronous to clock.
REQ-014 FSM states SHALL be IDLE, RUN and STEP; running = (state == RUN).
REQ-015 IDLE transitions SHALL be:
- stop edge: stay in IDLE.
- else start edge: go to RUN, presc <= 0.
- else step edge: go to STEP.
- else: stay in IDLE.
REQ-016 STEP SHALL last exactly one cycle, then return to IDLE with enable <= 1, producing exactly one pulse; stop/start/step edges during STEP are ignored.
REQ-017 In RUN, presc SHALL increment each cycle; when presc >= div, presc <= 0 and enable <= 1, otherwise enable <= 0.
REQ-018 With start first sampled high at edge E0, the first enable pulse SHALL be high in the cycle after edge E0+div+1; later pulses follow every div+1 cycles.
REQ-019 div SHALL be sampled live each cycle; lowering div below the current presc SHALL fire on the next cycle (>= compare), with no wrap through 2^DIV_W.
REQ-020 div = 0 in RUN SHALL give enable high every cycle.
REQ-021 A stop edge in RUN SHALL move to IDLE, clear presc and set enable <= 0 at that edge, even if presc >= div; stop has priority over the terminal-count check.
REQ-022 Projected count SHALL be the 4-bit sum count_in + enable.
REQ-023 In RUN with stop_at_tc = 1 and projected count = 4'hF, the block SHALL move to IDLE, set enable <= 0 and done <= 1 for one cycle, so the counter stops at 15 and never wraps.
REQ-024 With stop_at_tc = 0, RUN SHALL continue through the counter's 15->0 wrap with no done pulse.
REQ-025 In all states other than the cases above, enable and done SHALL be 0 in the next cycle; enable SHALL never be high for two cycles except in RUN with div = 0.
REQ-026 step edges in RUN and start edges in RUN SHALL be ignored.

Reset
REQ-027 On reset = 0 at a rising edge: state = IDLE, presc = 0, enable = 0, done = 0, running = 0.
REQ-028 Edge-history registers SHALL reset to 1, so inputs held high through reset do not trigger an edge.
REQ-029 Reset asserted mid-RUN SHALL drop enable in the following cycle, with no further pulses until a new start edge.

Verification
REQ-030 Reset, then div = 3, start rises -> running = 1 next cycle; enable pulses with a 4-cycle period; first pulse in the cycle after E0+4.
REQ-031 div = 0, stop_at_tc = 1, count_in fed by the real counter from 0 -> 15 consecutive enable pulses, counter holds at 15, done is a single pulse, running = 0.
REQ-032 IDLE, step rises three times -> exactly three one-cycle enable pulses; count_in advances 0 -> 3.
REQ-033 start and stop rise in the same cycle while in IDLE -> the FSM stays in IDLE with no enable pulse; stop rising in RUN at the cycle presc = div -> no pulse.
REQ-034 start held high through reset, then reset released -> no RUN entry until start falls and rises again.
REQ-035 In RUN with div = 10 and presc = 7, div changes to 2 -> enable pulse on the next cycle, then a 3-cycle period.
